// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// Holds the control FSM state encoding and digit-count arithmetic.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digits per operation; a zero DIGIT is rejected by the top-level check.
    function automatic int unsigned calc_ndig(input int unsigned width,
                                              input int unsigned digit);
        return (digit == 0) ? 1 : width / digit;
    endfunction

    // Digit counter width, never narrower than one bit.
    function automatic int unsigned calc_cnt_w(input int unsigned ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder, time-shared across all digits.
// Also exposes the carry into its MSB for signed-overflow detection.
module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum_c,
    output logic             cout_c,
    output logic             c_msb_c
);

    logic [DIGIT:0] carry_c;

    // Bit-by-bit ripple chain.
    always_comb begin
        carry_c    = '0;
        sum_c      = '0;
        carry_c[0] = cin;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            sum_c[i]       = a[i] ^ b[i] ^ carry_c[i];
            carry_c[i + 1] = (a[i] & b[i]) | (carry_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout_c  = carry_c[DIGIT];
    assign c_msb_c = carry_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, LSB first,
// with a valid/ready handshake on both the operand and the result side.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int unsigned CNT_W = calc_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    generate
        if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
            $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             accept_c;
    logic             last_c;
    logic [DIGIT-1:0] s_dig_c;
    logic             co_dig_c;
    logic             cm_dig_c;

    // Operands shift right each RUN cycle so the active digit is always at the bottom.
    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a       (a_q[DIGIT-1:0]),
        .b       (b_q[DIGIT-1:0]),
        .cin     (carry),
        .sum_c   (s_dig_c),
        .cout_c  (co_dig_c),
        .c_msb_c (cm_dig_c)
    );

    // Control state register; handshake flags are registered copies of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_DIG) begin
                    last_c    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then one digit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept_c) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            carry <= co_dig_c;
            for (int unsigned d = 0; d < NDIG; d++) begin
                if (cnt == CNT_W'(d)) begin
                    sum[d*DIGIT +: DIGIT] <= s_dig_c;
                end
            end
            if (last_c) begin
                cnt      <= '0;
                cout     <= co_dig_c;
                overflow <= co_dig_c ^ cm_dig_c;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: a 16-bit/4-bit instance and a
// 1-bit/1-bit instance, each checked against an arithmetic reference model.
module tb_digit_serial_adder;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned ND = W / D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
    logic [W-1:0] a, b, sum;

    logic         rst1_n, in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
    logic [0:0]   a1, b1, sum1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hold16 = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t q16[$];
    exp_t q1[$];

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
    );

    digit_serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst1_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer add of a, optionally inverted b, and carry; signed overflow by sign rule.
    function automatic exp_t model(input int unsigned w, input logic [W-1:0] av,
                                   input logic [W-1:0] bv, input logic ci,
                                   input logic sb, input int acc);
        exp_t r;
        longint unsigned mask, ae, be, tot, sa, sbb, ss;
        mask  = (64'd1 << w) - 64'd1;
        ae    = longint'(av) & mask;
        be    = longint'(bv) & mask;
        if (sb) be = (~be) & mask;
        tot   = ae + be + ((ci ^ sb) ? 64'd1 : 64'd0);
        r.sum  = W'(tot & mask);
        r.cout = ((tot >> w) & 64'd1) != 0;
        sa    = (ae >> (w - 1)) & 64'd1;
        sbb   = (be >> (w - 1)) & 64'd1;
        ss    = (tot >> (w - 1)) & 64'd1;
        r.ovf  = (sa == sbb) && (ss != sa);
        r.acc  = acc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic issue16(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic ci, input logic sb, input int hold);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL wait_in_ready16: got in_ready=0, expected 1 within 200 cycles");
        end
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        q16.push_back(model(W, av, bv, ci, sb, cyc));
        hold16 = hold;
        a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    endtask

    task automatic issue1(input logic av, input logic bv, input logic ci, input logic sb);
        int n = 0;
        while (!in_ready1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready1) begin
            checks++; errors++;
            $display("FAIL wait_in_ready1: got in_ready=0, expected 1 within 50 cycles");
        end
        a1 = av; b1 = bv; cin1 = ci; sub1 = sb; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        q1.push_back(model(1, W'(av), W'(bv), ci, sb, cyc));
        a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
    endtask

    // Result-side backpressure for the wide instance.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold16 > 0) begin
                out_ready = 1'b0;
                hold16--;
            end else begin
                out_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor for the wide instance: pop on out_valid rise, then hold/stability/idle checks.
    initial begin
        exp_t cur;
        bit   prev_v = 1'b0;
        bit   hs     = 1'b0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0; hs = 1'b0;
                continue;
            end
            if (hs) begin
                chk("in_ready_after_hs16", 32'(in_ready), 32'd1);
                chk("out_valid_after_hs16", 32'(out_valid), 32'd0);
                chk("sum_held_idle16", 32'(sum), 32'(cur.sum));
                hs = 1'b0;
            end
            if (out_valid) begin
                if (!prev_v) begin
                    if (q16.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result16: got out_valid=1, expected no pending operation");
                    end else begin
                        cur = q16.pop_front();
                        chk("latency16", 32'(cyc - cur.acc), 32'(ND));
                    end
                end
                chk("sum16", 32'(sum), 32'(cur.sum));
                chk("cout16", 32'(cout), 32'(cur.cout));
                chk("overflow16", 32'(overflow), 32'(cur.ovf));
                chk("in_ready_busy16", 32'(in_ready), 32'd0);
                if (out_ready) hs = 1'b1;
            end
            prev_v = out_valid;
        end
    end

    // Monitor for the 1-bit instance.
    initial begin
        exp_t cur;
        bit   prev_v = 1'b0;
        bit   hs     = 1'b0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst1_n) begin
                prev_v = 1'b0; hs = 1'b0;
                continue;
            end
            if (hs) begin
                chk("in_ready_after_hs1", 32'(in_ready1), 32'd1);
                hs = 1'b0;
            end
            if (out_valid1) begin
                if (!prev_v) begin
                    if (q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result1: got out_valid=1, expected no pending operation");
                    end else begin
                        cur = q1.pop_front();
                        chk("latency1", 32'(cyc - cur.acc), 32'd1);
                    end
                end
                chk("sum1", 32'(sum1), 32'(cur.sum[0]));
                chk("cout1", 32'(cout1), 32'(cur.cout));
                chk("overflow1", 32'(ovf1), 32'(cur.ovf));
                if (out_ready1) hs = 1'b1;
            end
            prev_v = out_valid1;
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; rst1_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_in_ready1", 32'(in_ready1), 32'd1);
        rst_n = 1'b1; rst1_n = 1'b1;

        // Full-adder truth table on the 1-bit instance.
        for (int i = 0; i < 8; i++) begin
            issue1(1'(i >> 2), 1'(i >> 1), 1'(i), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            issue1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Directed corner cases on the wide instance.
        issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        issue16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        issue16(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        issue16(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        issue16(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        // Backpressure: out_ready held low well into DONE.
        issue16(16'h1234, 16'h4321, 1'b1, 1'b0, ND + 6);

        // Abort after the second RUN edge.
        issue16(16'hABCD, 16'h1111, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        void'(q16.pop_back());
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        issue16(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            issue16(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Drain both scoreboards.
        n = 0;
        while ((q16.size() != 0 || q1.size() != 0 || out_valid || out_valid1) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_q16", 32'(q16.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits, at least 1.
REQ-002 Parameter DIGIT, default 4: bits added per clock; WIDTH mod DIGIT SHALL be 0, else elaboration fails.
REQ-003 Derived NDIG = WIDTH/DIGIT: digits per operation.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-006 in_valid  input  1  operands and mode valid.
REQ-007 in_ready  output  1  block idle and able to accept an operation.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in.
REQ-011 sub  input  1  mode select: 0 adds, 1 subtracts.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry-out of the MSB.
REQ-016 overflow  output  1  two's-complement signed overflow.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-018 Accept occurs on a rising edge with in_valid && in_ready; at accept the block latches a, b^{WIDTH{sub}}, cin^sub, moves to RUN and clears the digit counter.
REQ-019 In RUN, each edge adds one DIGIT-bit slice, LSB first, with the registered carry; it writes the slice into sum and advances the counter.
REQ-020 After the edge that processes digit NDIG-1, the FSM SHALL enter DONE; out_valid goes high exactly NDIG cycles after the accept edge (1 cycle when DIGIT==WIDTH).
REQ-021 Result: {cout,sum} = a + (b^{WIDTH{sub}}) + (cin^sub), modulo 2^(WIDTH+1); sub=1,cin=0 gives a-b, and sub=1,cin=1 gives a-b-1.
REQ-022 overflow SHALL equal carry into MSB XOR carry out of MSB; for WIDTH==1 the same rule applies with carry-in as the MSB carry-in.
REQ-023 In DONE, sum, cout and overflow SHALL hold stable until out_valid && out_ready; on that edge the FSM returns to IDLE.
REQ-024 No same-cycle restart: in_ready rises in the cycle after the result handshake.
REQ-025 While not in IDLE, changes on a, b, cin, sub and in_valid SHALL be ignored.
REQ-026 While in IDLE or RUN, out_ready SHALL be ignored.
REQ-027 sum, cout and overflow SHALL keep the last result through IDLE until the next operation writes them.
REQ-028 Digit counter width SHALL be max(1,$clog2(NDIG)); the counter wraps only via the state change to DONE.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, counter=0, carry=0, sum=0, cout=0 and overflow=0; in_ready=1 and out_valid=0.
REQ-030 A reset asserted in RUN or DONE SHALL abort the operation with no result presented.
REQ-031 After rst_n deasserts, the first accept is possible on the next rising edge.

Structure
REQ-032 Package adder_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the NDIG/counter-width helper function.
REQ-033 One sub-module, digit_adder (parameter DIGIT), SHALL be a combinational ripple adder with outputs DIGIT-bit sum, carry-out and carry into its MSB; it is instantiated once and time-shared across digits.

Verification
REQ-034 Test with WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, cin=0, sub=0 -> out_valid 4 cycles after accept, sum=0x0000, cout=1, overflow=0.
REQ-035 Test with WIDTH=16, DIGIT=4: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, overflow=1.
REQ-036 Test with WIDTH=16, DIGIT=4: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, overflow=0; repeat with cin=1 -> sum=0xFFFD.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, cout and overflow stable and in_ready=0 throughout; in_ready=1 one cycle after the handshake.
REQ-038 Reset abort: assert rst_n low after the 2nd RUN edge -> out_valid never rises, outputs read 0 and in_ready=1; a new operation then completes correctly.
REQ-039 Test with WIDTH=1, DIGIT=1, sub=0, all 8 combinations of a, b, cin -> {cout,sum} matches the full-adder truth table (for example 1,1,1 -> 2'b11), with out_valid 1 cycle after accept.
